// File: rtl/rib_ram_responder.sv
// RIB data-port RAM target with programmable wait states, plus a combinational
// instruction-fetch read port into the same word-addressed RAM.
module rib_ram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        hold_o,
  input  logic [31:0] pc_addr_i,
  output logic [31:0] pc_data_o
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("rib_ram_responder: WAIT_CYCLES must be 0..15");
  end
  if (DEPTH != (1 << AW)) begin : g_bad_depth
    $error("rib_ram_responder: DEPTH must be a power of two");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            cmd_we;
  logic            cmd_ok;
  logic [AW-1:0]   cmd_idx;
  logic [31:0]     cmd_wdata;

  logic [31:0]     mem [DEPTH];

  logic            c_we;
  logic            c_ok;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_wdata;
  logic            commit;
  logic            unused_bits;

  function automatic logic in_range(input logic [31:0] a);
    return (a[31:28] == BASE_ADDR[31:28]) && ({6'd0, a[27:2]} < 32'(DEPTH));
  endfunction

  // With zero wait states the commit happens on the sampling edge itself, so
  // the live inputs are used instead of the (not yet loaded) latched command.
  always_comb begin
    c_we    = cmd_we;
    c_ok    = cmd_ok;
    c_idx   = cmd_idx;
    c_wdata = cmd_wdata;
    commit  = 1'b0;
    if (state == S_IDLE) begin
      c_we    = we_i;
      c_ok    = in_range(addr_i);
      c_idx   = addr_i[AW+1:2];
      c_wdata = wdata_i;
      commit  = req_i && (WAIT_CYCLES == 0);
    end else if (state == S_WAIT) begin
      commit  = req_i && (cnt == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && c_ok) begin
      mem[c_idx] <= c_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cmd_we    <= 1'b0;
      cmd_ok    <= 1'b0;
      cmd_idx   <= '0;
      cmd_wdata <= 32'd0;
      rdata_o   <= 32'd0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i) begin
            cmd_we    <= we_i;
            cmd_ok    <= in_range(addr_i);
            cmd_idx   <= addr_i[AW+1:2];
            cmd_wdata <= wdata_i;
            cnt       <= CNT_INIT;
            state     <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req_i) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state <= S_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        ack_o <= 1'b1;
        err_o <= ~c_ok;
        // rdata only tracks reads; writes leave the last read value in place
        if (!c_we) begin
          rdata_o <= c_ok ? mem[c_idx] : 32'd0;
        end
      end
    end
  end

  assign hold_o      = req_i & ~ack_o & (state != S_ACK);
  assign pc_data_o   = in_range(pc_addr_i) ? mem[pc_addr_i[AW+1:2]] : 32'h0000_0013;
  assign unused_bits = ^{addr_i[1:0], pc_addr_i[1:0]};

endmodule

// File: tb/tb_rib_ram_responder.sv
// Directed bench for rib_ram_responder: one instance with 2 wait states, one with none.
module tb_rib_ram_responder;

  logic        clk;
  logic        rst;
  logic        req     [2];
  logic        we      [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [31:0] rdata   [2];
  logic        ack     [2];
  logic        err     [2];
  logic        hold    [2];
  logic [31:0] pc_addr [2];
  logic [31:0] pc_data [2];

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rib_ram_responder #(.BASE_ADDR(32'h1000_0000), .DEPTH(4096), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]),
    .hold_o(hold[0]), .pc_addr_i(pc_addr[0]), .pc_data_o(pc_data[0])
  );

  rib_ram_responder #(.BASE_ADDR(32'h1000_0000), .DEPTH(4096), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]),
    .hold_o(hold[1]), .pc_addr_i(pc_addr[1]), .pc_data_o(pc_data[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full handshake; lat counts negedges from driving req until ack is seen.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    #1 chk("hold_in_req", 32'(hold[d]), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack[d] && lat < 20);
    rd = rdata[d];
    er = err[d];
    chk("hold_in_ack", 32'(hold[d]), 32'd0);
    req[d] = 1'b0; we[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acks;
    logic        seen;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0; pc_addr[d] = 32'd0;
    end

    repeat (2) @(negedge clk);
    chk("rst_ack",   32'(ack[0]),  32'd0);
    chk("rst_err",   32'(err[0]),  32'd0);
    chk("rst_rdata", rdata[0],     32'd0);
    chk("rst_hold",  32'(hold[0]), 32'd0);
    chk("rst_ack_w0", 32'(ack[1]), 32'd0);
    rst = 1'b0;

    // Two wait states: write then read back
    xfer(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, rd, er, lat);
    chk("w2_wr_lat", 32'(lat), 32'd3);
    chk("w2_wr_err", 32'(er),  32'd0);
    xfer(0, 1'b0, 32'h1000_0010, 32'd0, rd, er, lat);
    chk("w2_rd_lat",   32'(lat), 32'd3);
    chk("w2_rd_data",  rd,       32'hDEAD_BEEF);
    chk("w2_rd_err",   32'(er),  32'd0);

    // Zero wait states
    xfer(1, 1'b1, 32'h1000_0004, 32'h1234_5678, rd, er, lat);
    chk("w0_wr_lat", 32'(lat), 32'd1);
    xfer(1, 1'b0, 32'h1000_0004, 32'd0, rd, er, lat);
    chk("w0_rd_lat",  32'(lat), 32'd1);
    chk("w0_rd_data", rd,       32'h1234_5678);
    chk("w0_rd_err",  32'(er),  32'd0);
    chk("w0_hold_idle", 32'(hold[1]), 32'd0);
    pc_addr[1] = 32'h1000_0004;
    #1 chk("w0_pc_word1", pc_data[1], 32'h1234_5678);

    // Out-of-range accesses; word 0 must survive an aliasing write beyond DEPTH
    xfer(0, 1'b1, 32'h1000_0000, 32'h1111_1111, rd, er, lat);
    chk("rdata_kept_on_wr", rd, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h2000_0000, 32'd0, rd, er, lat);
    chk("oor_rd_err",  32'(er), 32'd1);
    chk("oor_rd_data", rd,      32'd0);
    xfer(0, 1'b1, 32'h1000_4000, 32'hCAFE_F00D, rd, er, lat);
    chk("oor_wr_err", 32'(er), 32'd1);
    chk("oor_wr_lat", 32'(lat), 32'd3);
    pc_addr[0] = 32'h1000_0000;
    #1 chk("oor_word0_intact", pc_data[0], 32'h1111_1111);

    // Reset in the middle of a write's wait period
    xfer(0, 1'b1, 32'h1000_0020, 32'h5555_AAAA, rd, er, lat);
    xfer(0, 1'b0, 32'h1000_0020, 32'd0, rd, er, lat);
    chk("pre_rst_rd", rd, 32'h5555_AAAA);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1000_0020; wdata[0] = 32'hA5A5_A5A5;
    @(negedge clk);
    rst = 1'b1; req[0] = 1'b0; we[0] = 1'b0;
    #1;
    chk("midrst_ack",   32'(ack[0]),  32'd0);
    chk("midrst_err",   32'(err[0]),  32'd0);
    chk("midrst_rdata", rdata[0],     32'd0);
    chk("midrst_hold",  32'(hold[0]), 32'd0);
    acks = 0;
    repeat (2) begin @(negedge clk); if (ack[0]) acks++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (ack[0]) acks++; end
    chk("midrst_no_ack", 32'(acks), 32'd0);
    xfer(0, 1'b0, 32'h1000_0020, 32'd0, rd, er, lat);
    chk("post_rst_rd", rd, 32'h5555_AAAA);

    // Abort by dropping req during wait
    xfer(0, 1'b1, 32'h1000_0030, 32'h0102_0304, rd, er, lat);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1000_0030; wdata[0] = 32'h7777_7777;
    @(negedge clk);
    req[0] = 1'b0; we[0] = 1'b0;
    acks = 0;
    repeat (5) begin @(negedge clk); if (ack[0]) acks++; end
    chk("abort_no_ack", 32'(acks), 32'd0);
    pc_addr[0] = 32'h1000_0030;
    #1 chk("abort_no_write", pc_data[0], 32'h0102_0304);
    xfer(0, 1'b0, 32'h1000_0030, 32'd0, rd, er, lat);
    chk("reraise_lat",  32'(lat), 32'd3);
    chk("reraise_data", rd,       32'h0102_0304);

    // Fetch port sees the new word only from the commit edge onward
    xfer(0, 1'b1, 32'h1000_0008, 32'hAAAA_0001, rd, er, lat);
    pc_addr[0] = 32'h1000_0008;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1000_0008; wdata[0] = 32'hBBBB_0002;
    #1 chk("pc_old_at_req", pc_data[0], 32'hAAAA_0001);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ack[0]) begin
        seen = 1'b1;
        chk("pc_new_at_ack", pc_data[0], 32'hBBBB_0002);
      end else begin
        chk("pc_old_in_wait", pc_data[0], 32'hAAAA_0001);
      end
    end
    chk("pc_wr_acked", 32'(seen), 32'd1);
    req[0] = 1'b0; we[0] = 1'b0;
    pc_addr[0] = 32'h0000_0000;
    #1 chk("pc_nop_low", pc_data[0], 32'h0000_0013);
    pc_addr[0] = 32'h1000_4000;
    #1 chk("pc_nop_depth", pc_data[0], 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
